// File: rtl/jtag_cfgreg_pkg.sv
// Shared definitions for the JTAG configuration register bank.
//
// The DR frame is {wr, addr, data}, shifted LSB first. Its field positions
// depend on ADDR_W and DATA_W, so they are given as functions of those
// widths rather than as fixed constants.
//
// Contents:
//   frame_len / frame_wr_bit / frame_addr_lsb   frame geometry
//   lock_addr                                   address of the lock register
//   cfg_act_e                                   decoded action of one Update-DR
package jtag_cfgreg_pkg;

  // Total DR length: write flag + address + data.
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Bit position of the write flag (the MSB of the frame).
  function automatic int frame_wr_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  // Bit position of the address LSB. The address sits directly above the data.
  function automatic int frame_addr_lsb(input int data_w);
    return data_w;
  endfunction

  // The all-ones address selects the lock register.
  function automatic int lock_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

  // What a single Update-DR does.
  typedef enum logic [2:0] {
    ACT_NONE    = 3'd0,  // no update this cycle
    ACT_POINTER = 3'd1,  // wr=0: move the read pointer only
    ACT_WRITE   = 3'd2,  // write a configuration word
    ACT_LOCK    = 3'd3,  // write the lock register
    ACT_REJECT  = 3'd4   // write refused (locked or address hole)
  } cfg_act_e;

endpackage

// File: rtl/jtag_cfgreg_bank_if.sv
// TAP-side connection of the configuration register bank.
//
// The TAP controller drives the state strobes and tdi_i. The bank returns
// tdo_o. These are level signals sampled on the rising edge of TCK; there is
// no handshake. enable_i qualifies every strobe: when it is low, the bank
// ignores the strobes.
//
//   master : TAP controller side (drives the strobes, reads tdo_o)
//   slave  : register bank side
interface jtag_cfgreg_bank_if;
  logic enable_i;
  logic capture_dr_i;
  logic shift_dr_i;
  logic update_dr_i;
  logic tdi_i;
  logic tdo_o;

  modport master (
    output enable_i, capture_dr_i, shift_dr_i, update_dr_i, tdi_i,
    input  tdo_o
  );

  modport slave (
    input  enable_i, capture_dr_i, shift_dr_i, update_dr_i, tdi_i,
    output tdo_o
  );
endinterface

// File: rtl/jtag_cfgreg_bank.sv
// JTAG configuration register bank.
//
// A single addressable DR gives access to NUM_REGS configuration words and a
// sticky lock register.
//   - Capture loads {err, rd_ptr, word at rd_ptr} into the shift register.
//   - Shift moves the shift register one bit towards tdo.
//   - Update acts on the {wr, addr, data} frame that was shifted in.
//
// Ports:
//   clk_i     TCK
//   rst_ni    TRST, asynchronous, active low
//   tap       TAP strobes, tdi and tdo (slave modport)
//   cfg_o     configuration words, flat; word k is at [k*DATA_W +: DATA_W]
//   upd_o     one-cycle pulse per word, issued one clock after its write
//   locked_o  sticky write lock
//   err_o     the last update was rejected or addressed a hole
module jtag_cfgreg_bank
  import jtag_cfgreg_pkg::*;
#(
  parameter int                         NUM_REGS = 4,
  parameter int                         DATA_W   = 16,
  parameter int                         ADDR_W   = $clog2(NUM_REGS + 1),
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  jtag_cfgreg_bank_if.slave            tap,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_o,
  output logic [NUM_REGS-1:0]          upd_o,
  output logic                         locked_o,
  output logic                         err_o
);

  localparam int L      = frame_len(ADDR_W, DATA_W);
  localparam int WR_BIT = frame_wr_bit(ADDR_W, DATA_W);
  localparam int A_LSB  = frame_addr_lsb(DATA_W);
  localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(lock_addr(ADDR_W));

  logic [L-1:0]                     sr_q, sr_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  cfg_q, cfg_d;
  logic [ADDR_W-1:0]                rd_ptr_q, rd_ptr_d;
  logic                             locked_q, locked_d;
  logic                             err_q, err_d;
  logic [NUM_REGS-1:0]              upd_q, upd_d;

  // Fields of the frame that is currently held in the shift register.
  logic                             fr_wr;
  logic [ADDR_W-1:0]                fr_addr;
  logic [DATA_W-1:0]                fr_data;
  logic                             addr_is_reg;
  logic                             addr_is_lock;
  logic [DATA_W-1:0]                rd_data;
  cfg_act_e                         act;

  assign fr_wr        = sr_q[WR_BIT];
  assign fr_addr      = sr_q[WR_BIT-1:A_LSB];
  assign fr_data      = sr_q[DATA_W-1:0];
  assign addr_is_reg  = int'(fr_addr) < NUM_REGS;
  assign addr_is_lock = (fr_addr == LOCK_ADDR);

  // Read-back mux. Any pointer that is neither a word nor the lock
  // register reads as zero.
  always_comb begin
    rd_data = '0;
    if (rd_ptr_q == LOCK_ADDR) rd_data[0] = locked_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_ptr_q == ADDR_W'(k)) rd_data = cfg_q[k];
    end
  end

  // Strobe decode. Capture beats shift, and shift beats update, so
  // overlapping strobes from a misbehaving TAP still give defined results.
  // The lock address is tested before the locked check: writing the lock
  // register again is harmless, because the lock can only be set.
  always_comb begin
    act       = ACT_NONE;
    sr_d      = sr_q;
    cfg_d     = cfg_q;
    rd_ptr_d  = rd_ptr_q;
    locked_d  = locked_q;
    err_d     = err_q;
    upd_d     = '0;
    if (tap.enable_i) begin
      if (tap.capture_dr_i) begin
        sr_d = {err_q, rd_ptr_q, rd_data};
      end else if (tap.shift_dr_i) begin
        sr_d = {tap.tdi_i, sr_q[L-1:1]};
      end else if (tap.update_dr_i) begin
        rd_ptr_d = fr_addr;
        if (!fr_wr) begin
          act   = ACT_POINTER;
          err_d = !(addr_is_reg || addr_is_lock);
        end else if (addr_is_lock) begin
          act      = ACT_LOCK;
          locked_d = locked_q | fr_data[0];
          err_d    = 1'b0;
        end else if (addr_is_reg && !locked_q) begin
          act   = ACT_WRITE;
          err_d = 1'b0;
          for (int k = 0; k < NUM_REGS; k++) begin
            if (fr_addr == ADDR_W'(k)) begin
              cfg_d[k] = fr_data;
              upd_d[k] = 1'b1;
            end
          end
        end else begin
          act   = ACT_REJECT;
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sr_q <= '0;
    else         sr_q <= sr_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= RST_VAL;
      upd_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      upd_q <= upd_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign tap.tdo_o = sr_q[0];
  assign cfg_o     = cfg_q;
  assign upd_o     = upd_q;
  assign locked_o  = locked_q;
  assign err_o     = err_q;

  // act is kept as a named decode result for probing. This reference marks
  // it as used.
  logic act_unused;
  assign act_unused = ^act;

endmodule
